status_irq_ctrl: RTL and testbench

STATUS_IRQ_CTRL -- requirements
Module: status_irq_ctrl

---
 rtl/status_irq_ctrl.sv | 125 ++++++++++++
 tb/tb_status_irq_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/status_irq_ctrl.sv
// status_irq_ctrl: registered i2c status plus per-channel FIFO flags, sticky
// overflow/underflow flags, RX watermark and saturating error counters.
// Optional level interrupt built when STATUS_IRQ_EN is defined; otherwise irq
// is tied low and irq_en is ignored.
module status_irq_ctrl #(
  parameter int unsigned NUM_CH = 1,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned STAT_W = 5,
  parameter int unsigned ERR_W  = 8
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [STAT_W-1:0]         i2c_status,
  input  logic [NUM_CH-1:0]         tx_full,
  input  logic [NUM_CH-1:0]         tx_empty,
  input  logic [NUM_CH-1:0]         rx_full,
  input  logic [NUM_CH-1:0]         rx_empty,
  input  logic [NUM_CH-1:0]         rx_w_ena,
  input  logic [NUM_CH-1:0]         tx_r_ena,
  input  logic [NUM_CH*CNT_W-1:0]   rx_count,
  input  logic [CNT_W-1:0]          rx_thresh,
  input  logic                      clr_wr,
  input  logic [2*NUM_CH-1:0]       clr_mask,
  input  logic [NUM_CH*7+STAT_W-1:0] irq_en,
  output logic [NUM_CH*7+STAT_W-1:0] status_out,
  output logic [NUM_CH*ERR_W-1:0]   err_cnt,
  output logic                      irq
);

  localparam int unsigned SW  = NUM_CH * 7 + STAT_W;
  localparam int unsigned EVW = ERR_W + 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Bit offsets inside one channel's 7-bit field, LSB first.
  localparam int unsigned B_RX_WM    = 0;
  localparam int unsigned B_RX_EMPTY = 1;
  localparam int unsigned B_RX_FULL  = 2;
  localparam int unsigned B_RX_OVF   = 3;
  localparam int unsigned B_TX_EMPTY = 4;
  localparam int unsigned B_TX_FULL  = 5;
  localparam int unsigned B_TX_UNF   = 6;

  logic [SW-1:0]           status_q, status_d;
  logic [NUM_CH*ERR_W-1:0] err_q, err_d;

  logic [NUM_CH-1:0] ovf_ev, unf_ev, clr_flag, clr_cnt, wm;
  logic [ERR_W-1:0]  base_tmp;
  logic [EVW-1:0]    sum_tmp;

  assign ovf_ev = rx_full & rx_w_ena;
  assign unf_ev = tx_empty & tx_r_ena;

  // Decode per-channel clear strobes and watermark compare.
  always_comb begin
    clr_flag = '0;
    clr_cnt  = '0;
    wm       = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      clr_flag[c] = clr_wr & clr_mask[2*c];
      clr_cnt[c]  = clr_wr & clr_mask[2*c+1];
      wm[c]       = (rx_thresh != '0) && (rx_count[c*CNT_W +: CNT_W] >= rx_thresh);
    end
  end

  // Next status word and error counters; a set event beats a same-cycle clear.
  always_comb begin
    status_d = '0;
    err_d    = err_q;
    base_tmp = '0;
    sum_tmp  = '0;
    status_d[STAT_W-1:0] = i2c_status;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      status_d[STAT_W+7*c+B_RX_WM]    = wm[c];
      status_d[STAT_W+7*c+B_RX_EMPTY] = rx_empty[c];
      status_d[STAT_W+7*c+B_RX_FULL]  = rx_full[c];
      status_d[STAT_W+7*c+B_RX_OVF]   = ovf_ev[c] |
                                        (status_q[STAT_W+7*c+B_RX_OVF] & ~clr_flag[c]);
      status_d[STAT_W+7*c+B_TX_EMPTY] = tx_empty[c];
      status_d[STAT_W+7*c+B_TX_FULL]  = tx_full[c];
      status_d[STAT_W+7*c+B_TX_UNF]   = unf_ev[c] |
                                        (status_q[STAT_W+7*c+B_TX_UNF] & ~clr_flag[c]);

      base_tmp = clr_cnt[c] ? '0 : err_q[c*ERR_W +: ERR_W];
      sum_tmp  = EVW'(base_tmp) + EVW'(ovf_ev[c]) + EVW'(unf_ev[c]);
      err_d[c*ERR_W +: ERR_W] = (sum_tmp > EVW'(ERR_MAX)) ? ERR_MAX : sum_tmp[ERR_W-1:0];
    end
  end

  // Status and counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      status_q <= '0;
      err_q    <= '0;
    end else begin
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  assign status_out = status_q;
  assign err_cnt    = err_q;

`ifdef STATUS_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = |(status_d & irq_en);

  // Interrupt level registered alongside the status word it is derived from.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_en;

  assign unused_irq_en = ^irq_en;
  assign irq           = 1'b0;
`endif

endmodule

// File: tb/tb_status_irq_ctrl.sv
// Randomized bench for status_irq_ctrl with an in-bench behavioural model,
// directed scenarios for stickiness, clear priority, saturation, watermark,
// interrupt masking and asynchronous reset.
module tb_status_irq_ctrl;

  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 4;
  localparam int STAT_W  = 5;
  localparam int ERR_W   = 2;
  localparam int SW      = NUM_CH * 7 + STAT_W;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef STATUS_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    n_rst;
  logic [STAT_W-1:0]       i2c_status;
  logic [NUM_CH-1:0]       tx_full, tx_empty, rx_full, rx_empty, rx_w_ena, tx_r_ena;
  logic [NUM_CH*CNT_W-1:0] rx_count;
  logic [CNT_W-1:0]        rx_thresh;
  logic                    clr_wr;
  logic [2*NUM_CH-1:0]     clr_mask;
  logic [SW-1:0]           irq_en;
  logic [SW-1:0]           status_out;
  logic [NUM_CH*ERR_W-1:0] err_cnt;
  logic                    irq;

  status_irq_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .STAT_W(STAT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .n_rst(n_rst), .i2c_status(i2c_status),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .rx_w_ena(rx_w_ena), .tx_r_ena(tx_r_ena), .rx_count(rx_count), .rx_thresh(rx_thresh),
    .clr_wr(clr_wr), .clr_mask(clr_mask), .irq_en(irq_en),
    .status_out(status_out), .err_cnt(err_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  // Model state: what the outputs must be after the most recent edge.
  int m_ovf [NUM_CH];
  int m_unf [NUM_CH];
  int m_err [NUM_CH];
  logic [SW-1:0]           m_status;
  logic [NUM_CH*ERR_W-1:0] m_errvec;
  logic                    m_irq;
  // Model values for the coming edge.
  int n_ovf [NUM_CH];
  int n_unf [NUM_CH];
  int n_err [NUM_CH];
  logic [SW-1:0]           n_status;
  logic                    n_irq;

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_ovf[c] = 0; m_unf[c] = 0; m_err[c] = 0;
    end
    m_status = '0; m_errvec = '0; m_irq = 1'b0;
  endtask

  // Outcome of the next edge from the current inputs and model state.
  task automatic model_next();
    int ov, un, e, base;
    bit wm;
    n_status = '0;
    n_status[STAT_W-1:0] = i2c_status;
    for (int c = 0; c < NUM_CH; c++) begin
      ov = (rx_full[c] && rx_w_ena[c]) ? 1 : 0;
      un = (tx_empty[c] && tx_r_ena[c]) ? 1 : 0;
      n_ovf[c] = (ov == 1 || (m_ovf[c] == 1 && !(clr_wr && clr_mask[2*c]))) ? 1 : 0;
      n_unf[c] = (un == 1 || (m_unf[c] == 1 && !(clr_wr && clr_mask[2*c]))) ? 1 : 0;
      e = (clr_wr && clr_mask[2*c+1]) ? 0 : m_err[c];
      e = e + ov + un;
      if (e > ERR_MAX) e = ERR_MAX;
      n_err[c] = e;
      base = STAT_W + 7 * c;
      wm = (rx_thresh != 0) && (int'(rx_count[c*CNT_W +: CNT_W]) >= int'(rx_thresh));
      n_status[base+0] = wm;
      n_status[base+1] = rx_empty[c];
      n_status[base+2] = rx_full[c];
      n_status[base+3] = n_ovf[c][0];
      n_status[base+4] = tx_empty[c];
      n_status[base+5] = tx_full[c];
      n_status[base+6] = n_unf[c][0];
    end
    n_irq = IRQ_ON && ((n_status & irq_en) != '0);
  endtask

  // One clock: predict, take the edge, commit, settle 2 time units past it.
  task automatic cycle();
    model_next();
    @(posedge clk);
    m_ovf = n_ovf; m_unf = n_unf; m_err = n_err;
    m_status = n_status; m_irq = n_irq;
    for (int c = 0; c < NUM_CH; c++) m_errvec[c*ERR_W +: ERR_W] = ERR_W'(n_err[c]);
    #2;
  endtask

  task automatic idle();
    i2c_status = '0; tx_full = '0; tx_empty = '0; rx_full = '0; rx_empty = '0;
    rx_w_ena = '0; tx_r_ena = '0; rx_count = '0; rx_thresh = '0;
    clr_wr = 1'b0; clr_mask = '0; irq_en = '0;
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("status_out", 64'(status_out), 64'(m_status));
      check("err_cnt", 64'(err_cnt), 64'(m_errvec));
      check("irq", 64'(irq), 64'(m_irq));
    end
  end

  initial begin
    n_rst = 1'b0;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_status", 64'(status_out), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    #1;
    n_rst = 1'b1;
    chk_en = 1'b1;

    // i2c status passthrough
    i2c_status = 5'h15;
    cycle();
    check("i2c_pass", 64'(status_out[STAT_W-1:0]), 64'h15);

    // overflow sticky, then sticky clear leaves the counter
    idle();
    rx_full = 2'b01; rx_w_ena = 2'b01;
    cycle();
    rx_w_ena = 2'b00;
    check("ovf_set", 64'(status_out[STAT_W+3]), 64'd1);
    check("ovf_err1", 64'(err_cnt[ERR_W-1:0]), 64'd1);
    cycle();
    check("ovf_sticky", 64'(status_out[STAT_W+3]), 64'd1);
    clr_wr = 1'b1; clr_mask = 4'b0001;
    cycle();
    clr_wr = 1'b0;
    check("ovf_cleared", 64'(status_out[STAT_W+3]), 64'd0);
    check("ovf_err_kept", 64'(err_cnt[ERR_W-1:0]), 64'd1);

    // set event beats a same-cycle clear of flag and counter
    idle();
    clr_wr = 1'b1; clr_mask = 4'b0011;
    cycle();
    check("clr_cnt0", 64'(err_cnt[ERR_W-1:0]), 64'd0);
    tx_empty = 2'b01; tx_r_ena = 2'b01; clr_wr = 1'b1; clr_mask = 4'b0011;
    cycle();
    idle();
    check("unf_wins", 64'(status_out[STAT_W+6]), 64'd1);
    check("unf_cnt1", 64'(err_cnt[ERR_W-1:0]), 64'd1);

    // saturation and dual event
    clr_wr = 1'b1; clr_mask = 4'b0011;
    cycle();
    idle();
    rx_full = 2'b01; rx_w_ena = 2'b01;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("sat_seq", 64'(err_cnt[ERR_W-1:0]), 64'(sat_exp[i]));
    end
    idle();
    clr_wr = 1'b1; clr_mask = 4'b0010;
    cycle();
    idle();
    rx_full = 2'b01; rx_w_ena = 2'b01; tx_empty = 2'b01; tx_r_ena = 2'b01;
    cycle();
    idle();
    check("dual_evt", 64'(err_cnt[ERR_W-1:0]), 64'd2);
    check("ch1_untouched", 64'(err_cnt[2*ERR_W-1:ERR_W]), 64'd0);

    // watermark
    rx_thresh = 4'd4; rx_count = 8'h03;
    cycle();
    check("wm_below", 64'(status_out[STAT_W]), 64'd0);
    rx_count = 8'h04;
    cycle();
    check("wm_equal", 64'(status_out[STAT_W]), 64'd1);
    rx_thresh = 4'd0; rx_count = 8'hFF;
    cycle();
    check("wm_disabled", 64'(status_out[STAT_W]), 64'd0);
    check("wm_disabled1", 64'(status_out[STAT_W+7]), 64'd0);

    // interrupt masked to channel 1 overflow only
    idle();
    irq_en = '0;
    irq_en[STAT_W+7+3] = 1'b1;
    clr_wr = 1'b1; clr_mask = 4'b1111;
    cycle();
    clr_wr = 1'b0;
    check("irq_idle", 64'(irq), 64'd0);
    rx_full = 2'b01; rx_w_ena = 2'b01;
    cycle();
    rx_w_ena = 2'b00;
    check("irq_ch0_masked", 64'(irq), 64'd0);
    rx_full = 2'b10; rx_w_ena = 2'b10;
    cycle();
    rx_w_ena = 2'b00;
    check("irq_ch1", 64'(irq), 64'(IRQ_ON));
    clr_wr = 1'b1; clr_mask = 4'b0100;
    cycle();
    clr_wr = 1'b0;
    check("irq_cleared", 64'(irq), 64'd0);
    check("ch0_ovf_kept", 64'(status_out[STAT_W+3]), 64'd1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      i2c_status = STAT_W'($urandom);
      tx_full    = NUM_CH'($urandom);
      tx_empty   = NUM_CH'($urandom);
      rx_full    = NUM_CH'($urandom);
      rx_empty   = NUM_CH'($urandom);
      rx_w_ena   = NUM_CH'($urandom);
      tx_r_ena   = NUM_CH'($urandom);
      rx_count   = (NUM_CH*CNT_W)'($urandom);
      rx_thresh  = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom);
      clr_wr     = ($urandom_range(0, 3) == 0);
      clr_mask   = (2*NUM_CH)'($urandom);
      irq_en     = SW'($urandom);
      cycle();
    end

    // asynchronous reset between edges with live state
    idle();
    irq_en = '1;
    rx_full = 2'b11; rx_w_ena = 2'b11;
    cycle();
    check("pre_rst_ovf", 64'(status_out[STAT_W+3]), 64'd1);
    chk_en = 1'b0;
    #1;
    n_rst = 1'b0;
    #1;
    model_clear();
    check("async_status", 64'(status_out), 64'd0);
    check("async_err", 64'(err_cnt), 64'd0);
    check("async_irq", 64'(irq), 64'd0);
    @(posedge clk);
    #2;
    check("hold_status", 64'(status_out), 64'd0);
    rx_w_ena = 2'b00; tx_full = 2'b01;
    n_rst = 1'b1;
    chk_en = 1'b1;
    cycle();
    check("reload_rxfull", 64'(status_out[STAT_W+2]), 64'd1);
    check("reload_txfull", 64'(status_out[STAT_W+5]), 64'd1);
    check("no_ovf_survive", 64'(status_out[STAT_W+3]), 64'd0);
    check("no_err_survive", 64'(err_cnt), 64'd0);
    cycle();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
